// File: rtl/lock_seq_ctrl.sv
// Lock sequencer: collects a histogram frame, tracks its peak, hands it to the lock-metric
// calculator and filters verdicts through lock/unlock hysteresis. Optional watchdog: LOCK_SEQ_CTRL_TIMEOUT_EN.
module lock_seq_ctrl #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned BOUND_NUM       = 32,
  parameter int unsigned BOUND_NUM_WIDTH = 5,
  parameter int unsigned LOCK_CNT        = 4,
  parameter int unsigned UNLOCK_CNT      = 4,
  parameter int unsigned CNT_WIDTH       = 4,
  parameter int unsigned TIMEOUT         = 64,
  parameter int unsigned TIMEOUT_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [2:0]                      mode_i,
  input  logic                            bin_val_i,
  input  logic [DATA_WIDTH-1:0]           bin_data_i,
  input  logic                            bin_last_i,
  output logic                            bin_rdy_o,
  output logic [DATA_WIDTH*BOUND_NUM-1:0] calc_data_o,
  output logic [BOUND_NUM_WIDTH-1:0]      calc_max_num_o,
  output logic [2:0]                      calc_mode_o,
  output logic                            calc_val_o,
  input  logic                            calc_val_i,
  input  logic                            calc_lock_i,
  output logic                            lock_o,
  output logic                            lock_chg_o,
  output logic                            frame_err_o,
  output logic                            timeout_o
);

  // One extra bit so the bin counter can saturate at BOUND_NUM on over-long frames
  localparam int unsigned IDX_W = BOUND_NUM_WIDTH + 1;

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, UPDATE} state_t;

  state_t                                   state_q, state_nxt;
  logic [IDX_W-1:0]                         cnt_q, cnt_nxt;
  logic [BOUND_NUM-1:0][DATA_WIDTH-1:0]     frame_q, frame_nxt;
  logic [DATA_WIDTH-1:0]                    max_val_q, max_val_nxt;
  logic [BOUND_NUM_WIDTH-1:0]               max_idx_q, max_idx_nxt;
  logic                                     verdict_q, verdict_nxt;
  logic [CNT_WIDTH-1:0]                     good_q, good_nxt, bad_q, bad_nxt;
  logic                                     bin_rdy_nxt, calc_val_nxt, lock_nxt;
  logic                                     lock_chg_nxt, frame_err_nxt, timeout_nxt;
  logic [BOUND_NUM_WIDTH-1:0]               max_num_nxt;
  logic [2:0]                               mode_nxt;
  logic                                     accept_c, in_range_c, wd_expire_c;
  logic [CNT_WIDTH-1:0]                     good_inc_c, bad_inc_c;

  // The frame store doubles as the calculator data bus; it is stable outside COLLECT
  assign calc_data_o = frame_q;

  assign accept_c   = bin_val_i && bin_rdy_o;
  assign in_range_c = (cnt_q < IDX_W'(BOUND_NUM));
  assign good_inc_c = good_q + CNT_WIDTH'(1);
  assign bad_inc_c  = bad_q + CNT_WIDTH'(1);

`ifdef LOCK_SEQ_CTRL_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_q;

  assign wd_expire_c = (wd_q == TIMEOUT_WIDTH'(TIMEOUT - 1));

  // Watchdog counts WAIT cycles without a calculator response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (state_q == WAIT && !calc_val_i && !wd_expire_c) begin
      wd_q <= wd_q + TIMEOUT_WIDTH'(1);
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign wd_expire_c = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    frame_nxt     = frame_q;
    max_val_nxt   = max_val_q;
    max_idx_nxt   = max_idx_q;
    verdict_nxt   = verdict_q;
    good_nxt      = good_q;
    bad_nxt       = bad_q;
    bin_rdy_nxt   = bin_rdy_o;
    calc_val_nxt  = 1'b0;
    max_num_nxt   = calc_max_num_o;
    mode_nxt      = calc_mode_o;
    lock_nxt      = lock_o;
    lock_chg_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    timeout_nxt   = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (accept_c) begin
          if (cnt_q == '0) begin
            frame_nxt = '0;
            mode_nxt  = mode_i;
          end
          // Bins past BOUND_NUM are swallowed without touching store or peak
          if (in_range_c) begin
            frame_nxt[cnt_q[BOUND_NUM_WIDTH-1:0]] = bin_data_i;
            if (cnt_q == '0 || bin_data_i > max_val_q) begin
              max_val_nxt = bin_data_i;
              max_idx_nxt = cnt_q[BOUND_NUM_WIDTH-1:0];
            end
            cnt_nxt = cnt_q + IDX_W'(1);
          end
          if (bin_last_i) begin
            state_nxt     = ISSUE;
            bin_rdy_nxt   = 1'b0;
            calc_val_nxt  = 1'b1;
            max_num_nxt   = max_idx_nxt;
            frame_err_nxt = (cnt_q != IDX_W'(BOUND_NUM - 1));
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (calc_val_i) begin
          verdict_nxt = calc_lock_i;
          state_nxt   = UPDATE;
        end else if (wd_expire_c) begin
          verdict_nxt = 1'b0;
          timeout_nxt = 1'b1;
          state_nxt   = UPDATE;
        end
      end
      UPDATE: begin
        // Consecutive-verdict hysteresis around the lock state
        if (!lock_o) begin
          if (!verdict_q) begin
            good_nxt = '0;
          end else if (good_inc_c == CNT_WIDTH'(LOCK_CNT)) begin
            lock_nxt     = 1'b1;
            lock_chg_nxt = 1'b1;
            good_nxt     = '0;
            bad_nxt      = '0;
          end else begin
            good_nxt = good_inc_c;
          end
        end else begin
          if (verdict_q) begin
            bad_nxt = '0;
          end else if (bad_inc_c == CNT_WIDTH'(UNLOCK_CNT)) begin
            lock_nxt     = 1'b0;
            lock_chg_nxt = 1'b1;
            good_nxt     = '0;
            bad_nxt      = '0;
          end else begin
            bad_nxt = bad_inc_c;
          end
        end
        state_nxt   = COLLECT;
        bin_rdy_nxt = 1'b1;
        cnt_nxt     = '0;
        max_val_nxt = '0;
        max_idx_nxt = '0;
      end
      default: begin
        state_nxt   = COLLECT;
        bin_rdy_nxt = 1'b1;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= COLLECT;
      cnt_q          <= '0;
      frame_q        <= '0;
      max_val_q      <= '0;
      max_idx_q      <= '0;
      verdict_q      <= 1'b0;
      good_q         <= '0;
      bad_q          <= '0;
      bin_rdy_o      <= 1'b1;
      calc_val_o     <= 1'b0;
      calc_max_num_o <= '0;
      calc_mode_o    <= '0;
      lock_o         <= 1'b0;
      lock_chg_o     <= 1'b0;
      frame_err_o    <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      cnt_q          <= cnt_nxt;
      frame_q        <= frame_nxt;
      max_val_q      <= max_val_nxt;
      max_idx_q      <= max_idx_nxt;
      verdict_q      <= verdict_nxt;
      good_q         <= good_nxt;
      bad_q          <= bad_nxt;
      bin_rdy_o      <= bin_rdy_nxt;
      calc_val_o     <= calc_val_nxt;
      calc_max_num_o <= max_num_nxt;
      calc_mode_o    <= mode_nxt;
      lock_o         <= lock_nxt;
      lock_chg_o     <= lock_chg_nxt;
      frame_err_o    <= frame_err_nxt;
      timeout_o      <= timeout_nxt;
    end
  end

endmodule
